// File: rtl/alu_seq_if.sv
// Request/response bundle between the datapath controller and alu_seq.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       OPR;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] RH;
  logic             Co;
  logic             Z;
  logic             N;
  logic             V;

  modport master (
    output start, A, B, OPR,
    input  busy, done, R, RH, Co, Z, N, V
  );

  modport slave (
    input  start, A, B, OPR,
    output busy, done, R, RH, Co, Z, N, V
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with stored carry, status flags and a shift-add multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic      clock,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;

  localparam logic [3:0] OpPass = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpXor  = 4'd3;
  localparam logic [3:0] OpAsr  = 4'd4;
  localparam logic [3:0] OpShl  = 4'd5;
  localparam logic [3:0] OpAnd  = 4'd6;
  localparam logic [3:0] OpOr   = 4'd7;
  localparam logic [3:0] OpAdc  = 4'd8;
  localparam logic [3:0] OpSbc  = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;
  localparam logic [3:0] OpLsr  = 4'd11;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   r_q, r_d, rh_q, rh_d;
  logic               co_q, co_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   op_r;
  logic               op_co, op_v, op_ok;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CntW-1:0]    cnt_inc;

  // Single-cycle result and flags from the live operands and stored carry.
  always_comb begin
    ext   = '0;
    op_r  = '0;
    op_co = 1'b0;
    op_v  = 1'b0;
    op_ok = 1'b1;
    case (bus.OPR)
      OpPass: op_r = bus.B;
      OpSub, OpSbc: begin
        ext   = {1'b0, bus.A} - {1'b0, bus.B}
                - {{WIDTH{1'b0}}, (bus.OPR == OpSbc) & co_q};
        op_r  = ext[WIDTH-1:0];
        op_co = ext[WIDTH];
        op_v  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (op_r[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OpAdd, OpAdc: begin
        ext   = {1'b0, bus.A} + {1'b0, bus.B}
                + {{WIDTH{1'b0}}, (bus.OPR == OpAdc) & co_q};
        op_r  = ext[WIDTH-1:0];
        op_co = ext[WIDTH];
        op_v  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (op_r[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OpXor: op_r = bus.A ^ bus.B;
      OpAsr: op_r = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
      OpShl: op_r = {bus.A[WIDTH-2:0], 1'b0};
      OpAnd: op_r = bus.A & bus.B;
      OpOr:  op_r = bus.A | bus.B;
      OpMul: op_r = '0;
      OpLsr: begin
        op_r  = {1'b0, bus.A[WIDTH-1:1]};
        op_co = bus.A[0];
      end
      default: op_ok = 1'b0;
    endcase
  end

  // One shift-add step: WIDTH+1-bit sum keeps the carry before the right shift.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    cnt_inc = cnt_q + 1'b1;
  end

  // Sequencing: accept in IDLE, iterate in MUL, write results on completion.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    rh_d     = rh_q;
    co_d     = co_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    done_d   = 1'b0;
    if (state_q == StIdle) begin
      if (bus.start) begin
        if (bus.OPR == OpMul) begin
          mcand_d  = bus.A;
          mplier_d = bus.B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StMul;
        end else begin
          r_d    = op_r;
          rh_d   = '0;
          co_d   = op_co;
          z_d    = op_ok && (op_r == '0);
          n_d    = op_r[WIDTH-1];
          v_d    = op_v;
          done_d = 1'b1;
        end
      end
    end else begin
      acc_d    = acc_nxt;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_inc;
      if (cnt_inc == CntW'(WIDTH)) begin
        r_d     = acc_nxt[WIDTH-1:0];
        rh_d    = acc_nxt[2*WIDTH-1:WIDTH];
        co_d    = 1'b0;
        z_d     = (acc_nxt == '0);
        n_d     = acc_nxt[2*WIDTH-1];
        v_d     = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end
  end

  // State and result registers; reset aborts any multiply in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      rh_q     <= '0;
      co_q     <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      rh_q     <= rh_d;
      co_q     <= co_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == StMul);
  assign bus.done = done_q;
  assign bus.R    = r_q;
  assign bus.RH   = rh_q;
  assign bus.Co   = co_q;
  assign bus.Z    = z_q;
  assign bus.N    = n_q;
  assign bus.V    = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
  typedef struct packed {
    logic [15:0] r;
    logic [15:0] rh;
    logic [3:0]  f;  // {Co,Z,N,V}
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt8 = 0;
  int   done_cnt16 = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  alu_seq_if #(.WIDTH(8))  b8();
  alu_seq_if #(.WIDTH(16)) b16();

  alu_seq #(.WIDTH(8))  u_dut8  (.clock(clock), .reset(reset), .bus(b8));
  alu_seq #(.WIDTH(16)) u_dut16 (.clock(clock), .reset(reset), .bus(b16));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor for the 8-bit DUT: every done pops one expectation.
  always @(negedge clock) begin
    if (b8.done === 1'b1) begin
      done_cnt8++;
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done8_unexpected got=R%h RH%h exp=no done", b8.R, b8.RH);
      end else begin
        e8 = q8.pop_front();
        check("r8", 32'(b8.R), 32'(e8.r));
        check("rh8", 32'(b8.RH), 32'(e8.rh));
        check("flags8", 32'({b8.Co, b8.Z, b8.N, b8.V}), 32'(e8.f));
      end
    end
  end

  // Monitor for the 16-bit DUT.
  always @(negedge clock) begin
    if (b16.done === 1'b1) begin
      done_cnt16++;
      if (q16.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done16_unexpected got=R%h RH%h exp=no done", b16.R, b16.RH);
      end else begin
        e16 = q16.pop_front();
        check("r16", 32'(b16.R), 32'(e16.r));
        check("rh16", 32'(b16.RH), 32'(e16.rh));
        check("flags16", 32'({b16.Co, b16.Z, b16.N, b16.V}), 32'(e16.f));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit push, input exp_t e);
    b8.start = 1'b1;
    b8.OPR   = op;
    b8.A     = a;
    b8.B     = b;
    if (push) q8.push_back(e);
    @(posedge clock);
    #1 b8.start = 1'b0;
  endtask

  task automatic send16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e);
    b16.start = 1'b1;
    b16.OPR   = op;
    b16.A     = a;
    b16.B     = b;
    q16.push_back(e);
    @(posedge clock);
    #1 b16.start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (q8.size() == 0 && q16.size() == 0) break;
      @(posedge clock);
      #1;
    end
    check(name, 32'(q8.size() + q16.size()), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int dc0;
    bit saw_done;
    b8.start = 1'b0;  b8.OPR = '0;  b8.A = '0;  b8.B = '0;
    b16.start = 1'b0; b16.OPR = '0; b16.A = '0; b16.B = '0;
    #22 reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_r", 32'(b8.R), 32'd0);
    check("rst_rh", 32'(b8.RH), 32'd0);
    check("rst_flags", 32'({b8.Co, b8.Z, b8.N, b8.V}), 32'd0);
    check("rst_busy_done", 32'({b8.busy, b8.done}), 32'd0);

    // Reset in the middle of a multiply: no done, everything cleared.
    send8(4'd10, 8'h12, 8'h34, 1'b0, '0);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    check("mul_busy_before_rst", 32'(b8.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(b8.busy), 32'd0);
    check("rst_mid_r_rh", 32'({b8.R, b8.RH}), 32'd0);
    check("rst_mid_flags", 32'({b8.Co, b8.Z, b8.N, b8.V, b8.done}), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (12) begin
      @(posedge clock);
      #1;
    end
    check("rst_mid_no_done", 32'(done_cnt8), 32'd0);

    // Additions with carry and overflow.
    send8(4'd2, 8'hF0, 8'h20, 1'b1, '{r: 16'h10, rh: 16'h0, f: 4'b1000});
    check("add_done_next", 32'(b8.done), 32'd1);
    send8(4'd2, 8'h7F, 8'h01, 1'b1, '{r: 16'h80, rh: 16'h0, f: 4'b0011});
    drain("drain_add");

    // Multi-word chain through the stored carry, back to back.
    send8(4'd1, 8'h10, 8'h20, 1'b1, '{r: 16'hF0, rh: 16'h0, f: 4'b1010});
    send8(4'd8, 8'h01, 8'h01, 1'b1, '{r: 16'h03, rh: 16'h0, f: 4'b0000});
    send8(4'd9, 8'h00, 8'h00, 1'b1, '{r: 16'h00, rh: 16'h0, f: 4'b0100});
    drain("drain_chain");

    // Multiply with a start pulse while busy that must be ignored.
    dc0 = done_cnt8;
    send8(4'd10, 8'hFF, 8'hFF, 1'b1, '{r: 16'h01, rh: 16'hFE, f: 4'b0010});
    busy_cnt = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (b8.done === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
      if (b8.busy === 1'b1) busy_cnt++;
      if (i == 2) begin
        b8.start = 1'b1;
        b8.OPR   = 4'd2;
        b8.A     = 8'h01;
        b8.B     = 8'h01;
      end
      if (i == 3) b8.start = 1'b0;
    end
    check("mul_done_seen", 32'(saw_done), 32'd1);
    check("mul_busy_cycles", 32'(busy_cnt), 32'd8);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    check("mul_one_done", 32'(done_cnt8 - dc0), 32'd1);
    check("mul_hold", 32'({b8.RH, b8.R}), 32'h0000FE01);

    // Shifts, logic and a reserved opcode.
    send8(4'd4, 8'h81, 8'h00, 1'b1, '{r: 16'hC0, rh: 16'h0, f: 4'b0010});
    send8(4'd11, 8'h81, 8'h00, 1'b1, '{r: 16'h40, rh: 16'h0, f: 4'b1000});
    send8(4'd5, 8'h81, 8'h00, 1'b1, '{r: 16'h02, rh: 16'h0, f: 4'b0000});
    send8(4'd6, 8'hF0, 8'h0F, 1'b1, '{r: 16'h00, rh: 16'h0, f: 4'b0100});
    send8(4'd13, 8'hAA, 8'h55, 1'b1, '{r: 16'h00, rh: 16'h0, f: 4'b0000});
    check("rsvd_done", 32'(b8.done), 32'd1);
    drain("drain_shift");

    // Throughput on the 16-bit instance.
    dc0 = done_cnt16;
    send16(4'd0, 16'h0000, 16'h1234, '{r: 16'h1234, rh: 16'h0, f: 4'b0000});
    check("b2b_done1", 32'(b16.done), 32'd1);
    send16(4'd3, 16'hFFFF, 16'h00FF, '{r: 16'hFF00, rh: 16'h0, f: 4'b0010});
    check("b2b_done2", 32'(b16.done), 32'd1);
    drain("drain_16");
    @(posedge clock);
    #1;
    check("b2b_done_count", 32'(done_cnt16 - dc0), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the team's 8-bit combinational ALU.
- Keeps opcodes 0-7 with identical arithmetic and adds: a stored carry flag for multi-word ADC/SBC; full status flags (Z, N, V); a logical shift right; and a multi-cycle unsigned shift-add multiplier with a double-width result.
- Sits between the register file and the writeback stage of the datapath.
- Uses a start/busy/done handshake so the controller can stall on multi-cycle operations.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 4).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- A  in  WIDTH  operand A, captured on an accepted start.
- B  in  WIDTH  operand B, captured on an accepted start.
- OPR  in  4  opcode, captured on an accepted start.
- busy  out  1  high while a multiply is iterating.
- done  out  1  one-cycle pulse; R/RH/flags updated on the same edge.
- R  out  WIDTH  result (low half for MUL).
- RH  out  WIDTH  high half of the MUL product; 0 for all other ops.
- Co  out  1  carry/borrow flag; also the stored carry used by ADC/SBC.
- Z  out  1  zero flag.
- N  out  1  negative flag.
- V  out  1  signed overflow flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, R=0, RH=0, Co=0, Z=0, N=0, V=0; all internal registers cleared. Reset asserted mid-multiply aborts it, with no done pulse.
- Outputs R, RH and the flags hold their values until the next done. Flags change only on a done edge.
- Accepted start = start=1 && busy=0 at a rising edge. start while busy=1 is ignored, not queued.
- Opcodes and their {Co,R} results (arithmetic in WIDTH+1 bits):
  - 0 PASS: R=B, Co=0.
  - 1 SUB: {Co,R}=A-B. Co=1 means borrow (A<B unsigned).
  - 2 ADD: {Co,R}=A+B.
  - 3 XOR: R=A^B, Co=0.
  - 4 ASR: R={A[W-1],A[W-1:1]}, Co=0.
  - 5 SHL: R=A<<1, Co=0.
  - 6 AND: R=A&B, Co=0.
  - 7 OR: R=A|B, Co=0.
  - 8 ADC: {Co,R}=A+B+Co_old.
  - 9 SBC: {Co,R}=A-B-Co_old.
  - 10 MUL: {RH,R}=A*B unsigned, Co=0.
  - 11 LSR: R={1'b0,A[W-1:1]}, Co=A[0].
  - 12-15 reserved: R=0, RH=0, all flags 0, done still pulses.
- Flag rules:
  - V = signed overflow for ADD/ADC (operands same sign, result differs) and SUB/SBC (operands differ in sign, result sign differs from A); 0 for all other ops.
  - Z=1 iff R==0, and for MUL iff {RH,R}==0.
  - N = R[W-1]; for MUL, N = RH[W-1].
- Single-cycle ops (all except MUL): result registered on the accept edge itself. done=1 for the cycle that follows (latency 1 edge). busy stays 0. Back-to-back starts are accepted every cycle.
- FSM states: IDLE, MUL.
  - IDLE + accepted MUL start: load multiplicand=A, multiplier=B, accumulator=0, counter=0; go to MUL; busy=1 from the next cycle.
  - MUL: each edge, if multiplier LSB=1 then add multiplicand into the upper half of the 2*WIDTH accumulator (WIDTH+1-bit sum keeps the carry); shift the accumulator right 1; shift the multiplier right 1; counter++.
  - After WIDTH iterations: write {RH,R}, update flags, done=1, busy=0, return to IDLE.
  - Total: accept at edge k; busy high in the WIDTH cycles following k; results and done appear after edge k+WIDTH.
- A start in the same cycle that done is high is accepted normally, because busy is already 0.
- The counter is sized $clog2(WIDTH)+1 bits. There is no wrap-around: exit happens at count==WIDTH.

Test Plan:
- Reset mid-MUL: start MUL 0x12*0x34, assert reset after 3 cycles -> busy=0, done never pulses, R=RH=0, all flags 0.
- ADD 0xF0+0x20 -> next cycle done=1, R=0x10, Co=1, V=0, Z=0; ADD 0x7F+0x01 -> R=0x80, N=1, V=1, Co=0.
- Multi-word arithmetic:
  - SUB 0x10-0x20 -> R=0xF0, Co=1, N=1.
  - Then ADC 0x01+0x01 -> R=0x03, Co=0.
  - Then SBC 0x00-0x00 with Co=0 -> R=0x00, Z=1.
- MUL 0xFF*0xFF:
  - busy=1 for 8 cycles, then done with RH=0xFE, R=0x01, N=1, Z=0.
  - start pulsed during busy is ignored: exactly one done, and results are unchanged.
- Shifts and logic:
  - ASR 0x81 -> R=0xC0, Co=0.
  - LSR 0x81 -> R=0x40, Co=1.
  - SHL 0x81 -> R=0x02.
  - AND 0xF0&0x0F -> R=0x00, Z=1.
  - Reserved opcode 13 -> R=0, all flags 0, done=1.
- Throughput with WIDTH=16: back-to-back PASS B=0x1234 then XOR 0xFFFF^0x00FF on consecutive cycles -> done high 2 cycles, R=0x1234 then R=0xFF00, N=1.
